// File: rtl/cv32e41p_tb_obi_mem.sv
`default_nettype none
// cv32e41p_tb_obi_mem: multi-port OBI memory model, round-robin arbitrated, with exit register.
// Rev 1.0
module cv32e41p_tb_obi_mem #(
  parameter int          NUM_PORTS       = 2,
  parameter int          ADDR_WIDTH      = 20,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1,
  parameter logic [31:0] EXIT_ADDR       = 32'h2000_0004
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_PORTS-1:0]       req_i,
  output logic [NUM_PORTS-1:0]       gnt_o,
  input  logic [NUM_PORTS-1:0][31:0] addr_i,
  input  logic [NUM_PORTS-1:0]       we_i,
  input  logic [NUM_PORTS-1:0][3:0]  be_i,
  input  logic [NUM_PORTS-1:0][31:0] wdata_i,
  output logic [NUM_PORTS-1:0]       rvalid_o,
  output logic [NUM_PORTS-1:0][31:0] rdata_o,
  output logic                       exit_valid_o,
  output logic [31:0]                exit_value_o,
  output logic                       tests_passed_o,
  output logic                       tests_failed_o
);

  localparam int               PTR_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int               CNT_W         = $clog2(MAX_OUTSTANDING + 1);
  localparam int               WORDS         = 2 ** (ADDR_WIDTH - 2);
  localparam logic [PTR_W:0]   NP            = (PTR_W + 1)'(NUM_PORTS);
  localparam logic [CNT_W-1:0] MAX_OUT       = CNT_W'(MAX_OUTSTANDING);
  localparam logic [31:0]      UNMAPPED_DATA = 32'hDEAD_BEEF;

  logic [31:0]                                  mem [WORDS];
  logic [PTR_W-1:0]                             rr_ptr;
  logic [PTR_W-1:0]                             winner;
  logic [PTR_W:0]                               cand;
  logic                                         win_valid;
  logic                                         stall;
  logic                                         grant;
  logic [15:0]                                  lfsr;
  logic [NUM_PORTS-1:0]                         eligible;
  logic [NUM_PORTS-1:0][CNT_W-1:0]              outstanding;
  logic [NUM_PORTS-1:0][RESP_LATENCY-1:0]       pipe_v;
  logic [NUM_PORTS-1:0][RESP_LATENCY-1:0][31:0] pipe_d;
  logic [31:0]                                  sel_addr;
  logic [31:0]                                  sel_wdata;
  logic [3:0]                                   sel_be;
  logic                                         sel_we;
  logic [31:0]                                  resp_data;
  logic                                         hit_ram;
  logic                                         hit_exit;
  logic [ADDR_WIDTH-3:0]                        word_idx;

  assign stall = STALL_EN && (lfsr[1:0] == 2'b00);

  // A response retiring this cycle frees its slot for a grant in the same cycle.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = req_i[p] && ((outstanding[p] - CNT_W'(rvalid_o[p])) < MAX_OUT);
    end
  end

  // Scan from the farthest candidate down so the one nearest rr_ptr wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (cand >= NP) begin
        cand = cand - NP;
      end
      if (eligible[cand[PTR_W-1:0]]) begin
        win_valid = 1'b1;
        winner    = cand[PTR_W-1:0];
      end
    end
  end

  assign grant = win_valid && !stall && !rst_i;

  always_comb begin
    gnt_o = '0;
    if (grant) begin
      gnt_o[winner] = 1'b1;
    end
  end

  assign sel_addr  = addr_i[winner];
  assign sel_wdata = wdata_i[winner];
  assign sel_be    = be_i[winner];
  assign sel_we    = we_i[winner];
  assign hit_ram   = (sel_addr >> ADDR_WIDTH) == 32'd0;
  assign hit_exit  = !hit_ram && (sel_addr == EXIT_ADDR);
  assign word_idx  = sel_addr[ADDR_WIDTH-1:2];

  always_comb begin
    resp_data = '0;
    if (!sel_we) begin
      if (hit_ram) begin
        resp_data = mem[word_idx];
      end else if (hit_exit) begin
        resp_data = exit_value_o;
      end else begin
        resp_data = UNMAPPED_DATA;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant && sel_we && hit_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_be[b]) begin
          mem[word_idx][8*b +: 8] <= sel_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr         <= '0;
      lfsr           <= LFSR_SEED;
      outstanding    <= '0;
      pipe_v         <= '0;
      pipe_d         <= '0;
      exit_valid_o   <= 1'b0;
      exit_value_o   <= '0;
      tests_passed_o <= 1'b0;
      tests_failed_o <= 1'b0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (grant) begin
        if (({1'b0, winner} + 1'b1) >= NP) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= winner + 1'b1;
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        pipe_v[p][0] <= gnt_o[p];
        pipe_d[p][0] <= gnt_o[p] ? resp_data : 32'd0;
        for (int k = 1; k < RESP_LATENCY; k++) begin
          pipe_v[p][k] <= pipe_v[p][k-1];
          pipe_d[p][k] <= pipe_d[p][k-1];
        end
        case ({gnt_o[p], rvalid_o[p]})
          2'b10:   outstanding[p] <= outstanding[p] + 1'b1;
          2'b01:   outstanding[p] <= outstanding[p] - 1'b1;
          default: outstanding[p] <= outstanding[p];
        endcase
      end
      if (grant && sel_we && hit_exit) begin
        exit_valid_o   <= 1'b1;
        exit_value_o   <= sel_wdata;
        tests_passed_o <= (sel_wdata == 32'd0);
        tests_failed_o <= (sel_wdata != 32'd0);
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = pipe_v[p][RESP_LATENCY-1];
      rdata_o[p]  = pipe_d[p][RESP_LATENCY-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e41p_tb_obi_mem.sv
`default_nettype none
// tb_cv32e41p_tb_obi_mem: self-checking bench; instance a = defaults, b = latency 4 / limit 2,
// c = latency 3 with grant stalls (also used for reset mid-flight).
module tb_cv32e41p_tb_obi_mem;

  localparam logic [31:0] EXIT  = 32'h2000_0004;
  localparam logic [31:0] UNMAP = 32'h3000_0000;
  localparam logic [31:0] BEEF  = 32'hDEAD_BEEF;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sb_t;

  vec_t vecs [14];
  sb_t  sbq [2][$];
  bit   expg [24];

  logic            rst_a;
  logic [1:0]      req_a, gnt_a, we_a, rvalid_a;
  logic [1:0][31:0] addr_a, wdata_a, rdata_a;
  logic [1:0][3:0] be_a;
  logic            ev_a, pass_a, fail_a;
  logic [31:0]     eval_a;

  logic            rst_b;
  logic [0:0]      req_b, gnt_b, we_b, rvalid_b;
  logic [0:0][31:0] addr_b, wdata_b, rdata_b;
  logic [0:0][3:0] be_b;
  logic            ev_b, pass_b, fail_b;
  logic [31:0]     eval_b;

  logic            rst_c;
  logic [0:0]      req_c, gnt_c, we_c, rvalid_c;
  logic [0:0][31:0] addr_c, wdata_c, rdata_c;
  logic [0:0][3:0] be_c;
  logic            ev_c, pass_c, fail_c;
  logic [31:0]     eval_c;

  cv32e41p_tb_obi_mem dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr_a),
    .we_i(we_a), .be_i(be_a), .wdata_i(wdata_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
    .exit_valid_o(ev_a), .exit_value_o(eval_a), .tests_passed_o(pass_a), .tests_failed_o(fail_a)
  );

  cv32e41p_tb_obi_mem #(.NUM_PORTS(1), .ADDR_WIDTH(12), .RESP_LATENCY(4), .MAX_OUTSTANDING(2)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr_b),
    .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
    .exit_valid_o(ev_b), .exit_value_o(eval_b), .tests_passed_o(pass_b), .tests_failed_o(fail_b)
  );

  cv32e41p_tb_obi_mem #(.NUM_PORTS(1), .ADDR_WIDTH(12), .RESP_LATENCY(3), .MAX_OUTSTANDING(4),
                        .STALL_EN(1'b1), .LFSR_SEED(SEED)) dut_c (
    .clk_i(clk), .rst_i(rst_c), .req_i(req_c), .gnt_o(gnt_c), .addr_i(addr_c),
    .we_i(we_c), .be_i(be_c), .wdata_i(wdata_c), .rvalid_o(rvalid_c), .rdata_o(rdata_c),
    .exit_valid_o(ev_c), .exit_value_o(eval_c), .tests_passed_o(pass_c), .tests_failed_o(fail_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // Drives one request on instance a from posedge+1, pushes the expected response on grant.
  task automatic issue_a(input int p, input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic [31:0] exp, output int gcyc);
    bit got = 1'b0;
    gcyc = -1;
    req_a[p] = 1'b1; we_a[p] = we; addr_a[p] = a; be_a[p] = be; wdata_a[p] = d;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt_a[p]) begin
        got  = 1'b1;
        gcyc = cyc;
        sbq[p].push_back('{exp, cyc + 1});
      end
      @(posedge clk); #1;
    end
    req_a[p] = 1'b0;
    if (!got) chk("a_grant_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_gnt"}, {30'd0, gnt_a}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, rvalid_a}, 32'd0);
    chk({tag, "_rdata0"}, rdata_a[0], 32'd0);
    chk({tag, "_rdata1"}, rdata_a[1], 32'd0);
    chk({tag, "_exit"}, {29'd0, ev_a, pass_a, fail_a}, 32'd0);
    chk({tag, "_exit_value"}, eval_a, 32'd0);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (!rst_a) begin
      chk("a_gnt_without_req", {30'd0, gnt_a & ~req_a}, 32'd0);
      for (int p = 0; p < 2; p++) begin
        if (rvalid_a[p]) begin
          if (sbq[p].size() == 0) begin
            chk($sformatf("a_unexpected_rvalid_p%0d", p), {31'd0, rvalid_a[p]}, 32'd0);
          end else begin
            e = sbq[p].pop_front();
            chk($sformatf("a_rdata_p%0d", p), rdata_a[p], e.data);
            chk($sformatf("a_latency_p%0d", p), 32'(cyc), 32'(e.due));
          end
        end else if (sbq[p].size() != 0 && sbq[p][0].due <= cyc) begin
          chk($sformatf("a_missing_rvalid_p%0d", p), {31'd0, rvalid_a[p]}, 32'd1);
          void'(sbq[p].pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gc;
    int prev;
    int cnt;
    logic [15:0] m;

    vecs[0]  = '{0, 1'b1, 32'h0000_0100, 4'b1111, 32'h1234_5678, 32'h0};
    vecs[1]  = '{0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h1234_5678};
    vecs[2]  = '{0, 1'b1, 32'h0000_0200, 4'b1111, 32'hFFFF_FFFF, 32'h0};
    vecs[3]  = '{0, 1'b1, 32'h0000_0200, 4'b0001, 32'h0000_00AA, 32'h0};
    vecs[4]  = '{0, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,         32'hFFFF_FFAA};
    vecs[5]  = '{0, 1'b1, 32'h0000_0202, 4'b0010, 32'h0000_BB00, 32'h0};
    vecs[6]  = '{0, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,         32'hFFFF_BBAA};
    vecs[7]  = '{0, 1'b1, UNMAP,         4'b1111, 32'h1111_1111, 32'h0};
    vecs[8]  = '{1, 1'b0, UNMAP,         4'b1111, 32'h0,         BEEF};
    vecs[9]  = '{0, 1'b0, EXIT,          4'b1111, 32'h0,         32'h0};
    vecs[10] = '{0, 1'b1, 32'h000F_FFFC, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[11] = '{1, 1'b0, 32'h000F_FFFF, 4'b1111, 32'h0,         32'hCAFE_F00D};
    vecs[12] = '{1, 1'b0, 32'h0010_0000, 4'b1111, 32'h0,         BEEF};
    vecs[13] = '{0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,         32'h1234_5678};

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    req_a = 2'b11; we_a = 2'b00; addr_a[0] = UNMAP; addr_a[1] = UNMAP;
    be_a[0] = 4'hF; be_a[1] = 4'hF; wdata_a[0] = '0; wdata_a[1] = '0;
    req_b = 1'b1; we_b = 1'b0; addr_b[0] = UNMAP; be_b[0] = 4'hF; wdata_b[0] = '0;
    req_c = 1'b1; we_c = 1'b0; addr_c[0] = UNMAP; be_c[0] = 4'hF; wdata_c[0] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_a("a_reset");
    chk("b_reset", {27'd0, gnt_b, rvalid_b, ev_b, pass_b, fail_b}, 32'd0);
    chk("b_reset_data", eval_b | rdata_b[0], 32'd0);
    chk("c_reset", {27'd0, gnt_c, rvalid_c, ev_c, pass_c, fail_c}, 32'd0);
    chk("c_reset_data", eval_c | rdata_c[0], 32'd0);

    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0; req_a = 2'b00; req_b = 1'b0; req_c = 1'b0;

    prev = 0;
    for (int i = 0; i < 14; i++) begin
      issue_a(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp, gc);
      if (i > 0) chk($sformatf("a_throughput_%0d", i), 32'(gc), 32'(prev + 1));
      prev = gc;
    end
    repeat (3) @(posedge clk); #1;

    issue_a(0, 1'b1, EXIT, 4'hF, 32'd0, 32'd0, gc);
    @(negedge clk);
    chk("a_exit0_flags", {29'd0, ev_a, pass_a, fail_a}, 32'b110);
    chk("a_exit0_value", eval_a, 32'd0);
    repeat (3) @(posedge clk); #1;

    rst_a = 1'b1; req_a = 2'b11; we_a = 2'b00; addr_a[0] = UNMAP; addr_a[1] = UNMAP;
    @(negedge clk);
    chk_reset_a("a_rereset");
    @(posedge clk); #1;
    rst_a = 1'b0;

    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("a_rr_gnt_%0d", k), {30'd0, gnt_a}, (k % 2 == 0) ? 32'd1 : 32'd2);
      sbq[k % 2].push_back('{BEEF, cyc + 1});
      @(posedge clk); #1;
    end
    req_a = 2'b00;

    issue_a(1, 1'b1, EXIT, 4'hF, 32'd5, 32'd0, gc);
    @(negedge clk);
    chk("a_exit5_flags", {29'd0, ev_a, pass_a, fail_a}, 32'b101);
    chk("a_exit5_value", eval_a, 32'd5);
    @(posedge clk); #1;
    issue_a(0, 1'b0, EXIT, 4'hF, 32'd0, 32'd5, gc);
    issue_a(0, 1'b1, EXIT, 4'hF, 32'd0, 32'd0, gc);
    @(negedge clk);
    chk("a_exit_rewrite_flags", {29'd0, ev_a, pass_a, fail_a}, 32'b110);
    chk("a_exit_rewrite_value", eval_a, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("a_drain_p0", 32'(sbq[0].size()), 32'd0);
    chk("a_drain_p1", 32'(sbq[1].size()), 32'd0);

    // Latency 4 with two slots: two grants then two idle cycles, repeating.
    req_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("b_gnt_%0d", k), {31'd0, gnt_b}, ((k % 4) < 2) ? 32'd1 : 32'd0);
      chk($sformatf("b_rvalid_%0d", k), {31'd0, rvalid_b},
          (k >= 4 && ((k - 4) % 4) < 2) ? 32'd1 : 32'd0);
      if (k >= 4 && ((k - 4) % 4) < 2) chk($sformatf("b_rdata_%0d", k), rdata_b[0], BEEF);
      @(posedge clk); #1;
    end
    req_b = 1'b0;

    rst_c = 1'b0; req_c = 1'b1;
    m = SEED;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      expg[k] = (m[1:0] != 2'b00);
      chk($sformatf("c_stall_gnt_%0d", k), {31'd0, gnt_c}, {31'd0, expg[k]});
      chk($sformatf("c_stall_rvalid_%0d", k), {31'd0, rvalid_c}, (k >= 3) ? {31'd0, expg[k-3]} : 32'd0);
      m = lfsr_step(m);
      @(posedge clk); #1;
    end
    req_c = 1'b0;
    repeat (5) @(posedge clk); #1;

    req_c = 1'b1;
    gc = -1;
    for (int n = 0; n < 20 && gc < 0; n++) begin
      @(negedge clk);
      if (gnt_c[0]) gc = cyc;
      @(posedge clk); #1;
    end
    if (gc < 0) chk("c_grant_timeout", 32'(gc), 32'd0);
    rst_c = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("c_in_reset_%0d", k), {27'd0, gnt_c, rvalid_c, ev_c, pass_c, fail_c}, 32'd0);
      chk($sformatf("c_in_reset_data_%0d", k), rdata_c[0] | eval_c, 32'd0);
      @(posedge clk); #1;
    end
    rst_c = 1'b0; req_c = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rvalid_c[0]) cnt++;
    end
    chk("c_dropped_response", 32'(cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cv32e41p_tb_obi_mem.md
# cv32e41p_tb_obi_mem

Parametrised multi-port OBI memory model for the example testbench subsystem. It serves NUM_PORTS OBI requestors from one shared word RAM. Typical requestors are core instruction, core data and an optional DMA/debug master. Arbitration is round-robin, with optional pseudo-random grant stalls, a fixed response latency and a per-port outstanding limit. A memory-mapped exit register drives the bench's pass/fail/exit outputs.

## Interface
- NUM_PORTS, 2: number of OBI slave ports (1..4).
- ADDR_WIDTH, 20: RAM byte-address width; RAM is 2^ADDR_WIDTH bytes, word-organised.
- RESP_LATENCY, 1: cycles from grant to rvalid (1..8).
- MAX_OUTSTANDING, 2: per-port limit on granted-but-unanswered requests (1..8).
- STALL_EN, 0: 1 enables LFSR-driven grant stalls.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit stall LFSR (must be non-zero).
- EXIT_ADDR, 32'h2000_0004: byte address of the exit register.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS  per-port OBI request.
- gnt_o  out  NUM_PORTS  per-port OBI grant.
- addr_i  in  NUM_PORTS x 32  byte address.
- we_i  in  NUM_PORTS  write enable.
- be_i  in  NUM_PORTS x 4  byte enables.
- wdata_i  in  NUM_PORTS x 32  write data.
- rvalid_o  out  NUM_PORTS  response valid.
- rdata_o  out  NUM_PORTS x 32  response data.
- exit_valid_o  out  1  sticky; set on exit-register write.
- exit_value_o  out  32  value written to the exit register.
- tests_passed_o  out  1  sticky; set on exit write of 0.
- tests_failed_o  out  1  sticky; set on exit write of non-zero.

## Operation
- **Access rate:** one access per cycle in total across all ports.
- **Eligibility:** port p is eligible when req_i[p]=1 and outstanding[p] < MAX_OUTSTANDING.
- **Arbitration:** round-robin among eligible ports, starting at pointer rr_ptr.
- **Grant:** gnt_o[winner]=1 combinationally in the same cycle unless stall=1. All other gnt_o bits are 0.
- **Pointer update:** on a grant, rr_ptr <= winner+1, wrapping at NUM_PORTS. With no grant, rr_ptr holds.
- **Stall:** stall = STALL_EN && (lfsr[1:0]==2'b00).
  - The LFSR is a Fibonacci LFSR, taps 16,14,13,11. It advances every cycle.
- **Address decode** at grant:
  - addr < 2^ADDR_WIDTH: RAM word addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - addr == EXIT_ADDR: exit register.
  - Anything else: unmapped.
- **RAM write:** updates only the bytes with be=1. Response rdata = 32'h0.
- **RAM read:** returns the word as it stands at grant. No same-cycle write is possible.
- **Exit write:** exit_value_o <= wdata and exit_valid_o <= 1. tests_passed_o <= (wdata==0) and tests_failed_o <= (wdata!=0).
  - All four are sticky; a later exit write updates them, and passed/failed then follow the new value.
- **Exit read:** returns exit_value_o.
- **Unmapped access:** writes are ignored; reads return 32'hDEAD_BEEF.
- **Response pipe:** per port, depth RESP_LATENCY, carrying valid + data. Responses are strictly in grant order per port.
- **Outstanding counter:** outstanding[p] +1 on gnt_o[p], -1 on rvalid_o[p]; both in the same cycle gives net 0. Width is clog2(MAX_OUTSTANDING+1).
- **No backpressure:** rvalid_o is never held off; OBI requestors always accept.
- **Reset contents:** RAM contents are not reset; the bench preloads via $readmemh.

## Timing
- **Reset values:** gnt_o=0, rvalid_o=0, rdata_o=0, exit_valid_o=0, exit_value_o=0, tests_passed_o=0, tests_failed_o=0. Also rr_ptr=0, outstanding=0, lfsr=LFSR_SEED, response pipes empty.
- **Reset mid-operation:** in-flight responses are dropped; no rvalid follows for requests granted before reset.
- **Latency:** request granted in cycle T gives rvalid_o/rdata_o in cycle T+RESP_LATENCY, asserted for exactly one cycle.
- **Request hold:** a requestor holds req_i/addr/we/be/wdata until gnt_o. gnt_o is 0 whenever req_i is 0.
- **Outstanding limit:** at outstanding == MAX_OUTSTANDING the port gets no grant. It becomes eligible in the same cycle its rvalid_o retires an entry.
- **Throughput:** one port with RESP_LATENCY <= MAX_OUTSTANDING and STALL_EN=0 gets a grant every cycle.
- **Stall:** a stall cycle grants nothing but still advances the LFSR.
- **Exit outputs:** visible the cycle after the exit write is granted.

## Test plan
- **Single-port write/read:** write 32'h1234_5678, be=4'b1111, addr 0x100; then read 0x100 → rvalid exactly RESP_LATENCY cycles after each gnt; read returns 32'h1234_5678.
- **Byte enables:** write 32'hFFFF_FFFF, then write 32'h0000_00AA with be=4'b0001 to the same word → read returns 32'hFFFF_FFAA.
- **Round-robin:** NUM_PORTS=2, both ports request continuously, STALL_EN=0 → grants alternate p0,p1,p0,p1.
- **Outstanding limit:** RESP_LATENCY=4, MAX_OUTSTANDING=2, continuous requests on one port → two grants, two idle cycles, then the pattern repeats.
- **Exit register:**
  - Write 0 to EXIT_ADDR → next cycle exit_valid_o=1, tests_passed_o=1, exit_value_o=0.
  - After reset, write 5 → tests_failed_o=1, exit_value_o=5.
- **Reset mid-flight:** RESP_LATENCY=3, assert rst_i one cycle after a grant → no rvalid_o ever appears for that request; all outputs are 0 during reset.
